// File: rtl/led_seq_ctrl_pkg.sv
// Shared definitions for the LED sequencer: FSM state encoding, mode and
// direction constants, the default base-tick divider and a one-hot helper.
// No ports; imported by led_seq_ctrl and tick_gen.
package led_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic MODE_ROTATE = 1'b0;
    localparam logic MODE_BOUNCE = 1'b1;

    localparam logic DIR_TO_MSB  = 1'b0;
    localparam logic DIR_TO_LSB  = 1'b1;

    localparam int   DIV_BASE_DEF = 25000;

    function automatic logic is_onehot4(input logic [3:0] v);
        return ($countones(v) == 1);
    endfunction

endpackage

// File: rtl/led_seq_ctrl_tick_gen.sv
// Base-tick prescaler: counts 0..DIV-1 while enabled, pulses tick on the
//   terminal count (combinational from the count register, 0-cycle).
// Ports: clk, rst_n (async active-low), en (count), clr (sync clear, wins
//   over en), tick (one-cycle pulse). Frozen whenever en is low.
module tick_gen
    import led_seq_ctrl_pkg::*;
#(
    parameter int DIV = DIV_BASE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    logic [15:0] r_cnt;
    logic        w_term;

    assign w_term = (r_cnt == 16'(DIV - 1));
    assign tick   = en && !clr && w_term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_term ? 16'd0 : r_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// 4-bit LED sequencer (rotate / bounce) with IDLE/RUN/HOLD control FSM.
// Ports: clk, rst_n (async active-low), start/stop/pause one-cycle commands,
//   mode, dir, speed pattern controls; out pattern, busy, step pulse.
// step is registered and rises in the same cycle the new out value appears.
module led_seq_ctrl
    import led_seq_ctrl_pkg::*;
#(
    parameter int         DIV_BASE = DIV_BASE_DEF,
    parameter logic [3:0] INIT_PAT = 4'b1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       mode,
    input  logic       dir,
    input  logic [1:0] speed,
    output logic [3:0] out,
    output logic       busy,
    output logic       step
);

    state_t     r_state;
    state_t     w_state_nxt;

    logic [3:0] r_out;
    logic [1:0] r_scnt;     // base ticks seen in the current step period
    logic [1:0] r_speed;    // speed captured at start / last step boundary
    logic       r_bdir;     // bounce direction, DIR_TO_LSB after start
    logic       r_step;

    logic       w_tick;
    logic       w_pre_en;
    logic       w_pre_clr;
    logic       w_step_now;

    logic [3:0] w_out_nxt;
    logic       w_bdir_nxt;
    logic       w_bdir_eff;

    // Prescaler only advances in RUN; any stop/start or IDLE forces it to 0.
    assign w_pre_en  = (r_state == ST_RUN);
    assign w_pre_clr = (r_state == ST_IDLE) || start || stop;

    tick_gen #(
        .DIV (DIV_BASE)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_pre_en),
        .clr   (w_pre_clr),
        .tick  (w_tick)
    );

    // stop and start override any step landing in the same cycle.
    assign w_step_now = (r_state == ST_RUN) && !stop && !start &&
                        w_tick && (r_scnt == r_speed);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (stop) begin
            w_state_nxt = ST_IDLE;
        end else if (start) begin
            w_state_nxt = ST_RUN;
        end else if (pause) begin
            case (r_state)
                ST_RUN:  w_state_nxt = ST_HOLD;
                ST_HOLD: w_state_nxt = ST_RUN;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Next pattern; mode and dir are looked at only when a step is taken.
    always_comb begin
        w_out_nxt  = r_out;
        w_bdir_nxt = r_bdir;
        w_bdir_eff = r_bdir;
        if (!is_onehot4(r_out)) begin
            w_out_nxt = INIT_PAT;
        end else if (mode == MODE_ROTATE) begin
            if (dir == DIR_TO_MSB) begin
                w_out_nxt = {r_out[2:0], r_out[3]};
            end else begin
                w_out_nxt = {r_out[0], r_out[3:1]};
            end
        end else begin
            // An endpoint forces the only legal direction, so a stored
            // direction left stale by rotate mode can never shift out to 0.
            if (r_out == 4'b0001) begin
                w_bdir_eff = DIR_TO_MSB;
            end else if (r_out == 4'b1000) begin
                w_bdir_eff = DIR_TO_LSB;
            end
            w_out_nxt  = (w_bdir_eff == DIR_TO_LSB) ? (r_out >> 1) : (r_out << 1);
            w_bdir_nxt = w_bdir_eff;
            // Reverse on arrival so each endpoint is shown for one step.
            if (w_out_nxt == 4'b0001) begin
                w_bdir_nxt = DIR_TO_MSB;
            end else if (w_out_nxt == 4'b1000) begin
                w_bdir_nxt = DIR_TO_LSB;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out   <= 4'b0000;
            r_scnt  <= 2'd0;
            r_speed <= 2'd0;
            r_bdir  <= DIR_TO_LSB;
            r_step  <= 1'b0;
        end else begin
            r_step <= w_step_now;
            if (stop) begin
                r_out  <= 4'b0000;
                r_scnt <= 2'd0;
                r_bdir <= DIR_TO_LSB;
            end else if (start) begin
                r_out   <= INIT_PAT;
                r_scnt  <= 2'd0;
                r_speed <= speed;
                r_bdir  <= DIR_TO_LSB;
            end else if (r_state == ST_RUN && w_tick) begin
                if (w_step_now) begin
                    r_scnt  <= 2'd0;
                    r_out   <= w_out_nxt;
                    r_bdir  <= w_bdir_nxt;
                    r_speed <= speed;
                end else begin
                    r_scnt <= r_scnt + 2'd1;
                end
            end
        end
    end

    assign out  = r_out;
    assign busy = (r_state != ST_IDLE);
    assign step = r_step;

endmodule
